// File: rtl/dram_cmd_scheduler.sv
// rtl/dram_cmd_scheduler.sv - open-page DRAM command scheduler for one 8-bank rank
// Request handshake in, PRE/ACT/RD/WR/REF out on registered command pins.
module dram_cmd_scheduler #(
  parameter int T_RCD  = 3,
  parameter int T_RP   = 3,
  parameter int T_RFC  = 16,
  parameter int T_REFI = 1024
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic        refresh_force,
  output logic        chip_select,
  output logic        ras,
  output logic        cas,
  output logic        we,
  output logic [31:0] cmd_addr,
  output logic        resp_valid,
  output logic        refresh_busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_RW,
    S_PRE_ALL, S_WAIT_RP_ALL, S_REF, S_WAIT_RFC
  } state_e;

  localparam int RC_W = $clog2(T_REFI);
  localparam logic [RC_W-1:0] REFI_LOAD = RC_W'(T_REFI - 1);
  // Wait states hold for T_x-1 cycles, so the timer counts T_x-2 down to 0.
  localparam logic [15:0] RCD_LOAD = 16'(T_RCD - 2);
  localparam logic [15:0] RP_LOAD  = 16'(T_RP - 2);
  localparam logic [15:0] RFC_LOAD = 16'(T_RFC - 2);

  state_e            state_q, state_d;
  logic [15:0]       tmr_q, tmr_d;
  logic [15:0]       lrow_q, lrow_d;
  logic [9:0]        lcol_q, lcol_d;
  logic [2:0]        lbank_q, lbank_d;
  logic              lwrite_q, lwrite_d;
  logic [7:0]        open_q, open_d;
  logic [7:0][15:0]  row_q, row_d;
  logic [RC_W-1:0]   refcnt_q, refcnt_d;
  logic              pend_q, pend_d;
  logic              ref_done;

  logic              cs_q, cs_d;
  logic [2:0]        wcr_q, wcr_d;
  logic [31:0]       cmd_addr_q, cmd_addr_d;
  logic              resp_q, resp_d;
  logic              ready_q, ready_d;

  logic [2:0]        req_bank;
  logic              unused_addr_bits;

  assign req_bank         = req_addr[5:3];
  assign unused_addr_bits = ^req_addr[2:0];

  always_comb begin
    state_d  = state_q;
    tmr_d    = tmr_q;
    lrow_d   = lrow_q;
    lcol_d   = lcol_q;
    lbank_d  = lbank_q;
    lwrite_d = lwrite_q;
    open_d   = open_q;
    row_d    = row_q;
    ref_done = 1'b0;
    refcnt_d = (refcnt_q == '0) ? REFI_LOAD : refcnt_q - 1'b1;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          lrow_d   = req_addr[31:16];
          lcol_d   = req_addr[15:6];
          lbank_d  = req_bank;
          lwrite_d = req_write;
          if (open_q[req_bank] && row_q[req_bank] == req_addr[31:16]) state_d = S_RW;
          else if (open_q[req_bank])                                  state_d = S_PRE;
          else                                                        state_d = S_ACT;
        end else if (pend_q) begin
          state_d = (|open_q) ? S_PRE_ALL : S_REF;
        end
      end
      S_PRE: begin
        open_d[lbank_q] = 1'b0;
        if (T_RP == 1) state_d = S_ACT;
        else begin state_d = S_WAIT_RP; tmr_d = RP_LOAD; end
      end
      S_WAIT_RP: begin
        if (tmr_q == '0) state_d = S_ACT;
        else tmr_d = tmr_q - 1'b1;
      end
      S_ACT: begin
        open_d[lbank_q] = 1'b1;
        row_d[lbank_q]  = lrow_q;
        if (T_RCD == 1) state_d = S_RW;
        else begin state_d = S_WAIT_RCD; tmr_d = RCD_LOAD; end
      end
      S_WAIT_RCD: begin
        if (tmr_q == '0) state_d = S_RW;
        else tmr_d = tmr_q - 1'b1;
      end
      S_RW: state_d = S_IDLE;
      S_PRE_ALL: begin
        open_d = '0;
        if (T_RP == 1) state_d = S_REF;
        else begin state_d = S_WAIT_RP_ALL; tmr_d = RP_LOAD; end
      end
      S_WAIT_RP_ALL: begin
        if (tmr_q == '0) state_d = S_REF;
        else tmr_d = tmr_q - 1'b1;
      end
      S_REF: begin
        if (T_RFC == 1) begin state_d = S_IDLE; open_d = '0; ref_done = 1'b1; end
        else begin state_d = S_WAIT_RFC; tmr_d = RFC_LOAD; end
      end
      S_WAIT_RFC: begin
        if (tmr_q == '0) begin state_d = S_IDLE; open_d = '0; ref_done = 1'b1; end
        else tmr_d = tmr_q - 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    // Completion wins over a coincident expiry/force: refreshes never queue.
    pend_d = ref_done ? 1'b0 : (pend_q | (refcnt_q == '0) | refresh_force);
  end

  // Pins are decoded from the next state so every output leaves a flop.
  always_comb begin
    cs_d       = 1'b0;
    wcr_d      = 3'b111;
    cmd_addr_d = '0;
    resp_d     = 1'b0;
    case (state_d)
      S_PRE:     begin cs_d = 1'b1; wcr_d = 3'b000; cmd_addr_d = {26'b0, lbank_d, 3'b0}; end
      S_ACT:     begin cs_d = 1'b1; wcr_d = 3'b001; cmd_addr_d = {lrow_d, 10'b0, lbank_d, 3'b0}; end
      S_RW: begin
        cs_d       = 1'b1;
        wcr_d      = lwrite_d ? 3'b011 : 3'b010;
        cmd_addr_d = {16'b0, lcol_d, lbank_d, 3'b0};
        resp_d     = 1'b1;
      end
      S_PRE_ALL: begin cs_d = 1'b1; wcr_d = 3'b000; cmd_addr_d = 32'h0000_0001; end
      S_REF:     begin cs_d = 1'b1; wcr_d = 3'b100; end
      default:   ;
    endcase
    ready_d = (state_d == S_IDLE) && !pend_d;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      lrow_q     <= '0;
      lcol_q     <= '0;
      lbank_q    <= '0;
      lwrite_q   <= 1'b0;
      open_q     <= '0;
      row_q      <= '0;
      refcnt_q   <= REFI_LOAD;
      pend_q     <= 1'b0;
      cs_q       <= 1'b0;
      wcr_q      <= 3'b111;
      cmd_addr_q <= '0;
      resp_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      lrow_q     <= lrow_d;
      lcol_q     <= lcol_d;
      lbank_q    <= lbank_d;
      lwrite_q   <= lwrite_d;
      open_q     <= open_d;
      row_q      <= row_d;
      refcnt_q   <= refcnt_d;
      pend_q     <= pend_d;
      cs_q       <= cs_d;
      wcr_q      <= wcr_d;
      cmd_addr_q <= cmd_addr_d;
      resp_q     <= resp_d;
      ready_q    <= ready_d;
    end
  end

  assign req_ready    = ready_q;
  assign chip_select  = cs_q;
  assign we           = wcr_q[2];
  assign cas          = wcr_q[1];
  assign ras          = wcr_q[0];
  assign cmd_addr     = cmd_addr_q;
  assign resp_valid   = resp_q;
  assign refresh_busy = pend_q;

endmodule
